apb_req_arbiter: RTL and testbench

- Round-robin APB master that shares one APB slave port between NREQ local requesters.
- Accepts single-beat read/write requests, sequences IDLE/SETUP/ACCESS on the bus and returns per-requester responses.
- Contains an ACCESS-phase timeout so a stuck pready cannot hang the bus.
- Sits between the stimulus/CPU-side requesters and the APB slave (memory-backed, 32-bit address/data).

---
 rtl/apb_req_arbiter_if.sv | 20 ++
 rtl/apb_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// APB bus bundle between the request arbiter (master) and a 32-bit APB slave.
interface apb_req_arbiter_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        wr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    modport master (
        output paddr, psel, penable, wr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  paddr, psel, penable, wr, pwdata,
        output pready, prdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master: shares one APB slave between NREQ single-beat requesters,
// with back-to-back transfers and an ACCESS-phase timeout abort.
module apb_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [32*NREQ-1:0]     req_addr,
    input  logic [32*NREQ-1:0]     req_wdata,
    output logic [NREQ-1:0]        req_gnt,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    apb_req_arbiter_if.master      apb
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [31:0]            paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic                   wr_q, wr_d, psel_q, psel_d, penable_q, penable_d;
    logic [NREQ-1:0]        gnt_q, gnt_d, rspv_q, rspv_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;

    // Same bit layout as the flat ports: slice i at [32*i+31:32*i].
    logic [NREQ-1:0][31:0]  addr_a, wdata_a;
    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;

    logic [NREQ-1:0]        cand, owner_oh;
    logic                   win_found;
    logic [IW-1:0]          win_idx;
    int                     scan_j;

    // The current owner never competes on its own completing cycle.
    always_comb begin
        owner_oh         = '0;
        owner_oh[last_q] = (state_q == ACCESS);
        cand             = req_valid & ~owner_oh;
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        scan_j    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_j = int'(last_q) + k;
            if (scan_j >= NREQ) scan_j = scan_j - NREQ;
            if (!win_found && cand[IW'(scan_j)]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        wr_d      = wr_q;
        pwdata_d  = pwdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        gnt_d     = '0;
        rspv_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (apb.pready) begin
                    rspv_d[last_q] = 1'b1;
                    err_d          = 1'b0;
                    rdata_d        = wr_q ? 32'h0 : apb.prdata;
                    cnt_d          = '0;
                    if (!win_found) begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    rspv_d[last_q] = 1'b1;
                    err_d          = 1'b1;
                    rdata_d        = 32'h0;
                    cnt_d          = '0;
                    state_d        = IDLE;
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Grant from IDLE, or straight into SETUP on a clean completion (no abort).
        if (win_found && ((state_q == IDLE) || (state_q == ACCESS && apb.pready))) begin
            state_d         = SETUP;
            last_d          = win_idx;
            paddr_d         = addr_a[win_idx];
            pwdata_d        = wdata_a[win_idx];
            wr_d            = req_wr[win_idx];
            gnt_d[win_idx]  = 1'b1;
            psel_d          = 1'b1;
            penable_d       = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= IW'(NREQ-1);
            cnt_q     <= '0;
            paddr_q   <= '0;
            wr_q      <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            gnt_q     <= '0;
            rspv_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            wr_q      <= wr_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            gnt_q     <= gnt_d;
            rspv_q    <= rspv_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.wr      = wr_q;
    assign apb.pwdata  = pwdata_q;
    assign req_gnt     = gnt_q;
    assign rsp_valid   = rspv_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: vector table of single transfers plus
// contention, timeout and async-reset sequences against a memory-backed APB slave.
module tb_apb_req_arbiter;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic                pclk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_wr = '0;
    logic [32*NREQ-1:0]  req_addr = '0;
    logic [32*NREQ-1:0]  req_wdata = '0;
    logic [NREQ-1:0]     req_gnt, rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;

    apb_req_arbiter_if apb_bus();

    apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb(apb_bus)
    );

    always #5 pclk = ~pclk;

    // Slave: unwritten locations read back their own address.
    logic [31:0] mem [logic [31:0]];
    logic        pready_s = 1'b0;
    logic [31:0] prdata_s = '0;
    int          waits_cfg = 0;
    int          wait_cnt = 0;
    assign apb_bus.pready = pready_s;
    assign apb_bus.prdata = prdata_s;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a;
    endfunction

    always @(negedge pclk) begin
        if (apb_bus.psel && apb_bus.penable) begin
            if (wait_cnt < waits_cfg) begin
                pready_s = 1'b0;
                wait_cnt = wait_cnt + 1;
            end else begin
                pready_s = 1'b1;
            end
        end else begin
            pready_s = 1'b0;
            wait_cnt = 0;
        end
        prdata_s = mem_rd(apb_bus.paddr);
    end

    always @(posedge pclk)
        if (rst_n && apb_bus.psel && apb_bus.penable && pready_s && apb_bus.wr)
            mem[apb_bus.paddr] = apb_bus.pwdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          rq;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic set_req(input int rq, input bit w, input logic [31:0] a, input logic [31:0] d);
        req_valid[rq]         = 1'b1;
        req_wr[rq]            = w;
        req_addr[32*rq +: 32]  = a;
        req_wdata[32*rq +: 32] = d;
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        bit stable;
        waits_cfg = v.waits;
        @(negedge pclk);
        set_req(v.rq, v.wr, v.addr, v.wdata);
        @(negedge pclk);
        chk("gnt", 32'(req_gnt), 32'(1) << v.rq);
        chk("setup_psel", 32'(apb_bus.psel), 32'd1);
        chk("setup_penable", 32'(apb_bus.penable), 32'd0);
        chk("setup_paddr", apb_bus.paddr, v.addr);
        chk("setup_wr", 32'(apb_bus.wr), 32'(v.wr));
        req_valid[v.rq] = 1'b0;
        @(negedge pclk);
        chk("access_penable", 32'(apb_bus.penable), 32'd1);
        n = 0;
        stable = 1'b1;
        while (rsp_valid == '0 && n < 40) begin
            if (apb_bus.paddr !== v.addr || apb_bus.pwdata !== v.wdata || apb_bus.penable !== 1'b1)
                stable = 1'b0;
            @(negedge pclk);
            n++;
        end
        chk("rsp_latency", 32'(n), 32'(v.waits + 1));
        chk("access_stable", 32'(stable), 32'd1);
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << v.rq);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'd0);
        chk("idle_psel", 32'(apb_bus.psel), 32'd0);
    endtask

    vec_t tbl [6];

    initial begin
        int n;
        int pen;
        tbl[0] = '{0, 1'b1, 32'h10, 32'hA5A5_0001, 0, 32'h0};
        tbl[1] = '{1, 1'b0, 32'h10, 32'h0,         0, 32'hA5A5_0001};
        tbl[2] = '{0, 1'b0, 32'h20, 32'h0,         0, 32'h20};
        tbl[3] = '{1, 1'b1, 32'h30, 32'hDEAD_BEEF, 3, 32'h0};
        tbl[4] = '{0, 1'b0, 32'h30, 32'h1234_5678, 1, 32'hDEAD_BEEF};
        tbl[5] = '{1, 1'b0, 32'h05, 32'h0,         2, 32'h05};

        // Reset state
        #7;
        chk("rst_psel", 32'(apb_bus.psel), 32'd0);
        chk("rst_penable", 32'(apb_bus.penable), 32'd0);
        chk("rst_wr", 32'(apb_bus.wr), 32'd0);
        chk("rst_paddr", apb_bus.paddr, 32'd0);
        chk("rst_pwdata", apb_bus.pwdata, 32'd0);
        chk("rst_gnt", 32'(req_gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge pclk);
        rst_n = 1'b1;

        foreach (tbl[i]) do_txn(tbl[i]);
        chk("mem_write_10", mem_rd(32'h10), 32'hA5A5_0001);

        // Contention: last owner was requester 1, so 0 wins first, then 1 back-to-back.
        waits_cfg = 0;
        @(negedge pclk);
        set_req(0, 1'b0, 32'h05, 32'h0);
        set_req(1, 1'b0, 32'h06, 32'h0);
        @(negedge pclk);
        chk("cont_gnt0", 32'(req_gnt), 32'd1);
        chk("cont_psel_a", 32'(apb_bus.psel), 32'd1);
        req_valid[0] = 1'b0;
        @(negedge pclk);
        chk("cont_penable_a", 32'(apb_bus.penable), 32'd1);
        @(negedge pclk);
        chk("cont_rsp0", 32'(rsp_valid), 32'd1);
        chk("cont_rdata0", rsp_rdata, 32'h05);
        chk("cont_gnt1", 32'(req_gnt), 32'd2);
        chk("cont_psel_b2b", 32'(apb_bus.psel), 32'd1);
        chk("cont_penable_drop", 32'(apb_bus.penable), 32'd0);
        req_valid[1] = 1'b0;
        @(negedge pclk);
        chk("cont_penable_b", 32'(apb_bus.penable), 32'd1);
        chk("cont_paddr_b", apb_bus.paddr, 32'h06);
        @(negedge pclk);
        chk("cont_rsp1", 32'(rsp_valid), 32'd2);
        chk("cont_rdata1", rsp_rdata, 32'h06);
        chk("cont_idle", 32'(apb_bus.psel), 32'd0);
        set_req(0, 1'b0, 32'h07, 32'h0);
        set_req(1, 1'b0, 32'h08, 32'h0);
        @(negedge pclk);
        chk("rot_gnt0", 32'(req_gnt), 32'd1);
        req_valid[0] = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("rot_gnt1", 32'(req_gnt), 32'd2);
        chk("rot_rdata0", rsp_rdata, 32'h07);
        req_valid[1] = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("rot_rsp1", 32'(rsp_valid), 32'd2);
        chk("rot_rdata1", rsp_rdata, 32'h08);

        // Timeout: pready never rises, abort after TIMEOUT ACCESS cycles.
        waits_cfg = 1000;
        @(negedge pclk);
        set_req(0, 1'b1, 32'h40, 32'h1111_2222);
        @(negedge pclk);
        chk("to_gnt", 32'(req_gnt), 32'd1);
        req_valid[0] = 1'b0;
        pen = 0;
        n = 0;
        while (rsp_valid == '0 && n < 60) begin
            @(negedge pclk);
            n++;
            if (rsp_valid == '0 && apb_bus.penable) pen++;
        end
        chk("to_access_cycles", 32'(pen), 32'(TIMEOUT));
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        chk("to_psel", 32'(apb_bus.psel), 32'd0);
        chk("to_penable", 32'(apb_bus.penable), 32'd0);
        chk("to_no_write", mem_rd(32'h40), 32'h40);
        @(negedge pclk);
        chk("to_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("to_err_held", 32'(rsp_err), 32'd1);
        do_txn('{1, 1'b0, 32'h10, 32'h0, 0, 32'hA5A5_0001});

        // Async reset mid-ACCESS; requester 0 is in flight so the pointer sits on 0.
        waits_cfg = 1000;
        @(negedge pclk);
        set_req(0, 1'b1, 32'h50, 32'h0000_0077);
        @(negedge pclk);
        req_valid[0] = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("pre_rst_penable", 32'(apb_bus.penable), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_psel", 32'(apb_bus.psel), 32'd0);
        chk("arst_penable", 32'(apb_bus.penable), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_paddr", apb_bus.paddr, 32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        waits_cfg = 0;
        set_req(0, 1'b0, 32'h60, 32'h0);
        set_req(1, 1'b0, 32'h61, 32'h0);
        @(negedge pclk);
        chk("post_rst_gnt0", 32'(req_gnt), 32'd1);
        req_valid = '0;
        n = 0;
        while (rsp_valid == '0 && n < 10) begin
            @(negedge pclk);
            n++;
        end
        chk("post_rst_rsp", 32'(rsp_valid), 32'd1);
        chk("post_rst_rdata", rsp_rdata, 32'h60);
        chk("post_rst_no_write", mem_rd(32'h50), 32'h50);
        @(negedge pclk);
        chk("post_rst_idle", 32'(apb_bus.psel), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
